multicycle_cpu: RTL

Parametrised multi-cycle successor to the team's single-cycle 20-bit-instruction datapath. It executes the same instruction format (opcode/rs/rt/rd/funct/imm8) over a configurable data width. Each instruction runs through a FETCH/DECODE/EXEC/MEM/WB state machine. Instruction and data memories are external, each behind a req/ack handshake, so wait-state memories are supported. The block sits at the top of the processor subsystem, replacing the combinational-memory core.

---
 rtl/multicycle_cpu.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_cpu.sv
// Multi-cycle 20-bit-instruction CPU: FETCH/DECODE/EXEC/MEM/WB sequencing with
// req/ack instruction and data ports, so wait-state memories can be attached.
module multicycle_cpu #(
  parameter int              DATA_W   = 16,
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              ireq,
  output logic [PC_W-1:0]   iaddr,
  input  logic [19:0]       irdata,
  input  logic              iack,
  output logic              dreq,
  output logic              dwe,
  output logic [PC_W-1:0]   daddr,
  output logic [DATA_W-1:0] dwdata,
  input  logic [DATA_W-1:0] drdata,
  input  logic              dack,
  output logic [PC_W-1:0]   pc,
  output logic              retire,
  output logic              halted,
  output logic              illegal
);

  localparam logic [3:0] OP_RTYPE = 4'd0;
  localparam logic [3:0] OP_ADDI  = 4'd1;
  localparam logic [3:0] OP_ANDI  = 4'd2;
  localparam logic [3:0] OP_ORI   = 4'd3;
  localparam logic [3:0] OP_LW    = 4'd4;
  localparam logic [3:0] OP_SW    = 4'd5;
  localparam logic [3:0] OP_BEQ   = 4'd6;
  localparam logic [3:0] OP_BNE   = 4'd7;
  localparam logic [3:0] OP_HALT  = 4'd8;

  localparam logic [3:0] F_ADD = 4'd0;
  localparam logic [3:0] F_SUB = 4'd1;
  localparam logic [3:0] F_AND = 4'd2;
  localparam logic [3:0] F_OR  = 4'd3;
  localparam logic [3:0] F_XOR = 4'd4;
  localparam logic [3:0] F_SLT = 4'd5;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  state_t            state_reg, state_next;
  logic [PC_W-1:0]   pc_reg, pc_next;
  logic [19:0]       ir_reg;
  logic [DATA_W-1:0] a_reg, b_reg, result_reg;
  logic              ireq_reg, dreq_reg, dwe_reg, illegal_reg;
  logic [PC_W-1:0]   daddr_reg;
  logic [DATA_W-1:0] dwdata_reg;
  logic              retire_c;

  logic [DATA_W-1:0] rf [16];

  logic [3:0] op, rs, rt, rd, funct;
  logic [7:0] imm;
  assign op    = ir_reg[19:16];
  assign rs    = ir_reg[15:12];
  assign rt    = ir_reg[11:8];
  assign rd    = ir_reg[7:4];
  assign funct = ir_reg[3:0];
  assign imm   = ir_reg[7:0];

  logic [DATA_W-1:0] sext_imm, zext_imm;
  assign sext_imm = DATA_W'($signed(imm));
  assign zext_imm = DATA_W'(imm);

  logic illegal_op, is_branch, is_mem, branch_taken;
  assign illegal_op   = ((op == OP_RTYPE) && (funct > F_SLT)) || (op > OP_HALT);
  assign is_branch    = (op == OP_BEQ) || (op == OP_BNE);
  assign is_mem       = (op == OP_LW) || (op == OP_SW);
  assign branch_taken = (op == OP_BEQ) ? (a_reg == b_reg) : (a_reg != b_reg);

  // R-type writes rd; every other register-writing opcode targets rt.
  logic [3:0] wb_dst;
  assign wb_dst = (op == OP_RTYPE) ? rd : rt;

  logic [DATA_W-1:0] alu_result;
  always_comb begin
    alu_result = '0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          F_ADD:   alu_result = a_reg + b_reg;
          F_SUB:   alu_result = a_reg - b_reg;
          F_AND:   alu_result = a_reg & b_reg;
          F_OR:    alu_result = a_reg | b_reg;
          F_XOR:   alu_result = a_reg ^ b_reg;
          F_SLT:   alu_result = ($signed(a_reg) < $signed(b_reg)) ? DATA_W'(1) : '0;
          default: alu_result = '0;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW: alu_result = a_reg + sext_imm;
      OP_ANDI:               alu_result = a_reg & zext_imm;
      OP_ORI:                alu_result = a_reg | zext_imm;
      default:               alu_result = '0;
    endcase
  end

  always_comb begin
    pc_next = pc_reg + PC_W'(1);
    if (is_branch && branch_taken)
      pc_next = pc_reg + PC_W'(1) + PC_W'($signed(imm));
  end

  always_comb begin
    state_next = state_reg;
    retire_c   = 1'b0;
    case (state_reg)
      S_FETCH: begin
        if (ireq_reg && iack)
          state_next = S_DECODE;
      end
      S_DECODE: begin
        if (illegal_op || (op == OP_HALT))
          state_next = S_HALT;
        else
          state_next = S_EXEC;
      end
      S_EXEC: begin
        if (is_branch) begin
          retire_c   = 1'b1;
          state_next = S_FETCH;
        end else if (is_mem) begin
          state_next = S_MEM;
        end else begin
          state_next = S_WB;
        end
      end
      S_MEM: begin
        if (dreq_reg && dack) begin
          if (op == OP_SW) begin
            retire_c   = 1'b1;
            state_next = S_FETCH;
          end else begin
            state_next = S_WB;
          end
        end
      end
      S_WB: begin
        retire_c   = 1'b1;
        state_next = S_FETCH;
      end
      default: state_next = S_HALT;
    endcase
  end

  // Requests are registered from the next state so they drop asynchronously
  // on reset and rise exactly when the access state is entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= S_FETCH;
      pc_reg      <= RESET_PC;
      ir_reg      <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      result_reg  <= '0;
      ireq_reg    <= 1'b0;
      dreq_reg    <= 1'b0;
      dwe_reg     <= 1'b0;
      daddr_reg   <= '0;
      dwdata_reg  <= '0;
      illegal_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      ireq_reg  <= (state_next == S_FETCH);
      dreq_reg  <= (state_next == S_MEM);
      if (retire_c)
        pc_reg <= pc_next;
      case (state_reg)
        S_FETCH: begin
          if (ireq_reg && iack)
            ir_reg <= irdata;
        end
        S_DECODE: begin
          a_reg <= rf[rs];
          b_reg <= rf[rt];
          if (illegal_op)
            illegal_reg <= 1'b1;
        end
        S_EXEC: begin
          result_reg <= alu_result;
          if (is_mem) begin
            daddr_reg  <= PC_W'(alu_result);
            dwdata_reg <= b_reg;
            dwe_reg    <= (op == OP_SW);
          end
        end
        S_MEM: begin
          if (dreq_reg && dack && (op == OP_LW))
            result_reg <= drdata;
        end
        default: ;
      endcase
    end
  end

  // r0 is never written, so it always reads as zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++)
        rf[i] <= '0;
    end else if ((state_reg == S_WB) && (wb_dst != 4'd0)) begin
      rf[wb_dst] <= result_reg;
    end
  end

  assign ireq    = ireq_reg;
  assign iaddr   = pc_reg;
  assign dreq    = dreq_reg;
  assign dwe     = dwe_reg;
  assign daddr   = daddr_reg;
  assign dwdata  = dwdata_reg;
  assign pc      = pc_reg;
  assign retire  = retire_c;
  assign halted  = (state_reg == S_HALT);
  assign illegal = illegal_reg;

endmodule
